// File: rtl/sma_fb_inv.sv
// sma_fb_inv: inverse of the feedback moving average, rebuilding x from the running sum.
// Optional macro SMA_FB_INV_SAT_EN saturates out-of-range samples instead of wrapping them.
module sma_fb_inv #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = DATA_W + $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              resync_i,
    input  logic [ACC_W-1:0]  acc_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] x_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              err_o
);
    typedef enum logic {RUN, ERR} state_t;
    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_prev_q, acc_prev_d;
    logic [DATA_W-1:0] h_q [DEPTH];
    logic [DATA_W-1:0] h_d [DEPTH];
    logic [DATA_W-1:0] x_q, x_d, ovf;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W:0]    d;
    logic [ACC_W+1:0]  r;
    logic              in_range, beat;

    assign in_ready_o  = !resync_i && (!out_valid_q || out_ready_i);
    assign beat        = in_valid_i && in_ready_o;
    assign d           = {acc_i[ACC_W-1], acc_i} - {acc_prev_q[ACC_W-1], acc_prev_q};
    assign r           = {d[ACC_W], d} + {{(ACC_W+2-DATA_W){h_q[DEPTH-1][DATA_W-1]}}, h_q[DEPTH-1]};
    // r fits DATA_W bits exactly when all bits from the DATA_W sign position upward agree
    assign in_range    = &r[ACC_W+1:DATA_W-1] || ~|r[ACC_W+1:DATA_W-1];
    assign x_o         = x_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = state_q == ERR;
`ifdef SMA_FB_INV_SAT_EN
    assign ovf = r[ACC_W+1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign ovf = r[DATA_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_prev_d  = acc_prev_q;
        h_d         = h_q;
        x_d         = x_q;
        out_valid_d = out_valid_q && !out_ready_i;
        if (beat && state_q == RUN) begin
            x_d         = in_range ? r[DATA_W-1:0] : ovf;
            out_valid_d = 1'b1;
            acc_prev_d  = acc_i;
            h_d[0]      = x_d;
            for (int i = 1; i < DEPTH; i++) h_d[i] = h_q[i-1];
            state_d     = in_range ? RUN : ERR;
        end
        if (resync_i) begin
            state_d     = RUN;
            acc_prev_d  = '0;
            h_d         = '{default: '0};
            x_d         = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            acc_prev_q  <= '0;
            h_q         <= '{default: '0};
            x_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_prev_q  <= acc_prev_d;
            h_q         <= h_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_sma_fb_inv.sv
// tb_sma_fb_inv: table vectors, stall/overflow/resync/reset sequences and a random
// stream rebuilt against a windowed-sum reference model.
module tb_sma_fb_inv;
    localparam int N = 1000;
    logic        clk = 1'b0;
    logic        rst_n, resync, in_valid, in_ready, out_valid, out_ready, err;
    logic [17:0] acc;
    logic [15:0] x;
    int          errors = 0;
    int          checks = 0;
    int          got[$];
    int          xs[N];
    int          accs[N];
    bit          done;

    typedef struct {int acc; int x;} vec_t;
    vec_t t1[5];

    sma_fb_inv dut (
        .clk(clk), .rst_n(rst_n), .resync_i(resync), .acc_i(acc),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .x_o(x),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && out_valid && out_ready) got.push_back(int'($signed(x)));

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; resync = 1'b0; out_ready = 1'b1; acc = '0;
        #12;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        got.delete();
    endtask

    task automatic send_beat(input int v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        acc = 18'(v);
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk) ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic run_table(input string tag);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            acc = 18'(t1[i].acc);
            @(posedge clk); #1;
            chk({tag, "_valid"}, int'(out_valid), 1);
            chk({tag, "_x"}, int'($signed(x)), t1[i].x);
            chk({tag, "_err"}, int'(err), 0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_drain"}, int'(out_valid), 0);
    endtask

    task automatic cmp_queue(input string tag, input int e[$]);
        chk({tag, "_count"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++) chk(tag, got[i], e[i]);
    endtask

    initial begin
        t1[0] = '{100, 100};
        t1[1] = '{300, 200};
        t1[2] = '{0, -300};
        t1[3] = '{400, 400};
        t1[4] = '{300, 0};

        rst_n = 1'b0; in_valid = 1'b0; resync = 1'b0; out_ready = 1'b1; acc = '0;
        #3;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        do_reset();
        run_table("s1");

        do_reset();
        send_beat(100);
        send_beat(300);
        out_ready = 1'b0;
        acc = 18'(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s2_hold_x", int'($signed(x)), 200);
            chk("s2_hold_valid", int'(out_valid), 1);
            chk("s2_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_beat(0);
        send_beat(400);
        send_beat(300);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_queue("s2_stream", '{100, 200, -300, 400, 0});

        do_reset();
        send_beat(0);
        send_beat(40000);
        in_valid = 1'b0;
`ifdef SMA_FB_INV_SAT_EN
        chk("s3_ovf_x", int'($signed(x)), 32767);
`else
        chk("s3_ovf_x", int'($signed(x)), -25536);
`endif
        chk("s3_ovf_valid", int'(out_valid), 1);
        chk("s3_err", int'(err), 1);
        send_beat(500);
        in_valid = 1'b0;
        chk("s3_no_valid", int'(out_valid), 0);
        send_beat(700);
        in_valid = 1'b0;
        @(negedge clk);
        chk("s3_no_valid2", int'(out_valid), 0);
        chk("s3_err_sticky", int'(err), 1);

        @(posedge clk); #1;
        resync = 1'b1;
        @(negedge clk);
        chk("s4_in_ready_resync", int'(in_ready), 0);
        @(posedge clk); #1;
        resync = 1'b0;
        chk("s4_err", int'(err), 0);
        chk("s4_valid", int'(out_valid), 0);
        run_table("s4");

        do_reset();
        in_valid = 1'b1;
        acc = 18'(100);
        @(posedge clk); #1;
        acc = 18'(300);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("s5_pre_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_valid", int'(out_valid), 0);
        chk("s5_x", int'(x), 0);
        chk("s5_err", int'(err), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_table("s5");

        for (int n = 0; n < N; n++) begin
            xs[n] = int'($urandom_range(0, 15998)) - 7999;
            accs[n] = 0;
            for (int j = 0; j < 4; j++) if (n - j >= 0) accs[n] += xs[n-j];
        end
        do_reset();
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < N; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send_beat(accs[n]);
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = $urandom_range(0, 2) != 0;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && got.size() < N; k++) @(posedge clk);
        #1;
        chk("s6_count", got.size(), N);
        for (int i = 0; i < N && i < got.size(); i++) chk("s6_x", got[i], xs[i]);
        chk("s6_err", int'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
